// File: rtl/sigmoid_pkg.sv
// Shared widths, latency and segment tables for the piecewise-linear sigmoid.
// Tables hold sigmoid at segment endpoints in unsigned Q1.15.
package sigmoid_pkg;
  localparam int X_W     = 16;
  localparam int Y_W     = 16;
  localparam int A_W     = 15;
  localparam int SEG_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int D_W     = 13;
  localparam int PROD_W  = D_W + FRAC_W;
  localparam int LATENCY = 4;
  localparam int NSEG    = 32;

  localparam logic [X_W-1:0] X_MIN = 16'h8000;
  localparam logic [Y_W-1:0] Y_ONE = 16'h8000;
  localparam logic [PROD_W-1:0] RND = PROD_W'(1 << (FRAC_W - 1));

  // B[k] = round(sigmoid(k/4) * 32768)
  localparam logic [Y_W-1:0] B_TAB [NSEG] = '{
    16'd16384, 16'd18421, 16'd20397, 16'd22255,
    16'd23955, 16'd25471, 16'd26790, 16'd27917,
    16'd28862, 16'd29644, 16'd30282, 16'd30799,
    16'd31214, 16'd31545, 16'd31807, 16'd32015,
    16'd32179, 16'd32307, 16'd32408, 16'd32487,
    16'd32549, 16'd32597, 16'd32635, 16'd32664,
    16'd32687, 16'd32705, 16'd32719, 16'd32730,
    16'd32738, 16'd32745, 16'd32750, 16'd32754
  };

  // E[k] = round(sigmoid((k+1)/4) * 32768)
  localparam logic [Y_W-1:0] E_TAB [NSEG] = '{
    16'd18421, 16'd20397, 16'd22255, 16'd23955,
    16'd25471, 16'd26790, 16'd27917, 16'd28862,
    16'd29644, 16'd30282, 16'd30799, 16'd31214,
    16'd31545, 16'd31807, 16'd32015, 16'd32179,
    16'd32307, 16'd32408, 16'd32487, 16'd32549,
    16'd32597, 16'd32635, 16'd32664, 16'd32687,
    16'd32705, 16'd32719, 16'd32730, 16'd32738,
    16'd32745, 16'd32750, 16'd32754, 16'd32757
  };
endpackage

// File: rtl/sigmoid_seg_lut.sv
// Segment lookup: base value and rise across one 0.25-wide segment.
// Purely combinational; the pipeline registers its outputs.
module sigmoid_seg_lut
  import sigmoid_pkg::*;
(
  input  logic [SEG_W-1:0] k_i,
  output logic [Y_W-1:0]   b_o,
  output logic [D_W-1:0]   d_o
);

  assign b_o = B_TAB[k_i];
  // Largest rise is the first segment (2037), well inside 13 bits.
  assign d_o = D_W'(E_TAB[k_i] - B_TAB[k_i]);

endmodule

// File: rtl/sigmoid_pipelined.sv
// Four-stage free-running sigmoid: |x|, segment lookup, interpolate, mirror.
// Negative inputs use sigmoid(-x) = 1 - sigmoid(x).
module sigmoid_pipelined
  import sigmoid_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_in,
  input  logic [X_W-1:0] data_in,
  output logic           valid_out,
  output logic [Y_W-1:0] data_out
);

  logic [LATENCY-1:0] v_q;

  logic           s1_q, s2_q, s3_q, s4_q;
  logic [A_W-1:0] a1_q, a1_d;

  logic [FRAC_W-1:0] f2_q;
  logic [Y_W-1:0]    b2_q;
  logic [D_W-1:0]    d2_q;

  logic [Y_W-1:0] b3_q;
  logic [D_W-1:0] p3_q, p3_d;

  logic [Y_W-1:0] y4_q, y4_d;

  logic [Y_W-1:0] lut_b;
  logic [D_W-1:0] lut_d;

  // -0x8000 has no positive twin; clamp to the largest magnitude.
  always_comb begin
    a1_d = data_in[A_W-1:0];
    if (data_in == X_MIN)
      a1_d = '1;
    else if (data_in[X_W-1])
      a1_d = A_W'(-data_in);
  end

  sigmoid_seg_lut u_lut (
    .k_i (a1_q[A_W-1:FRAC_W]),
    .b_o (lut_b),
    .d_o (lut_d)
  );

  assign p3_d = D_W'((PROD_W'(d2_q) * PROD_W'(f2_q) + RND) >> FRAC_W);
  assign y4_d = b3_q + Y_W'(p3_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      s1_q <= 1'b0;
      a1_q <= '0;
      s2_q <= 1'b0;
      f2_q <= '0;
      b2_q <= '0;
      d2_q <= '0;
      s3_q <= 1'b0;
      b3_q <= '0;
      p3_q <= '0;
      s4_q <= 1'b0;
      y4_q <= '0;
    end else begin
      v_q  <= {v_q[LATENCY-2:0], valid_in};
      s1_q <= data_in[X_W-1];
      a1_q <= a1_d;
      s2_q <= s1_q;
      f2_q <= a1_q[FRAC_W-1:0];
      b2_q <= lut_b;
      d2_q <= lut_d;
      s3_q <= s2_q;
      b3_q <= b2_q;
      p3_q <= p3_d;
      s4_q <= s3_q;
      y4_q <= y4_d;
    end
  end

  assign valid_out = v_q[LATENCY-1];
  assign data_out  = s4_q ? (Y_ONE - y4_q) : y4_q;

endmodule

// File: tb/tb_sigmoid_pipelined.sv
// Self-checking bench for sigmoid_pipelined against a real-math model.
// Tables in the model come from $exp, independent of the RTL package.
module tb_sigmoid_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        valid_out;
  logic [15:0] data_out;

  int checks = 0;
  int failures = 0;
  int tab [33];

  always #5 clk = ~clk;

  sigmoid_pipelined dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  function automatic logic [15:0] ref_sig(input logic [15:0] x);
    int xs, a, k, f, p, y;
    xs = int'($signed(x));
    a = (xs < 0) ? -xs : xs;
    if (a > 32767) a = 32767;
    k = a / 1024;
    f = a % 1024;
    p = ((tab[k+1] - tab[k]) * f + 512) / 1024;
    y = tab[k] + p;
    return 16'((xs < 0) ? 32768 - y : y);
  endfunction

  // Sample outputs just after an edge, then drive the next input.
  task automatic tick(input logic v, input logic [15:0] x,
                      output logic vo, output logic [15:0] yo);
    @(posedge clk);
    #1;
    vo = valid_out;
    yo = data_out;
    valid_in = v;
    data_in = x;
  endtask

  task automatic test_reset;
    logic vo;
    logic [15:0] yo;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'($urandom), vo, yo);
      checks++;
      if (vo !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid got=%b want=0", vo);
      end
      checks++;
      if (yo !== 16'h0000) begin
        failures++;
        $display("FAIL reset_data got=%h want=0000", yo);
      end
    end
    rst = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'($urandom), vo, yo);
      checks++;
      if (vo !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_valid cyc=%0d got=%b want=0", i, vo);
      end
    end
  endtask

  task automatic test_directed;
    logic vo;
    logic [15:0] yo;
    logic [15:0] xs [7] = '{16'h0000, 16'h1000, 16'hF000, 16'h7FFF,
                            16'h8000, 16'h0001, 16'hFFFF};
    logic [15:0] want [7] = '{16'h4000, 16'h5D93, 16'h226D, 16'h7FF5,
                              16'h000B, 16'h4002, 16'h3FFE};
    for (int i = 0; i < 11; i++) begin
      tick(i < 7, (i < 7) ? xs[i % 7] : 16'h0, vo, yo);
      if (i >= 4) begin
        checks++;
        if (vo !== 1'b1) begin
          failures++;
          $display("FAIL directed_valid x=%h got=%b want=1", xs[i-4], vo);
        end
        checks++;
        if (yo !== want[i-4]) begin
          failures++;
          $display("FAIL directed_data x=%h got=%h want=%h",
                   xs[i-4], yo, want[i-4]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 200;
    logic vo;
    logic [15:0] yo;
    logic [15:0] xq [N];
    logic vq [N];
    for (int i = 0; i < N + 4; i++) begin
      if (i < N) begin
        xq[i] = 16'($urandom);
        vq[i] = ((i % 4) != 1);
        tick(vq[i], xq[i], vo, yo);
      end else begin
        tick(1'b0, 16'h0, vo, yo);
      end
      if (i >= 4) begin
        checks++;
        if (vo !== vq[i-4]) begin
          failures++;
          $display("FAIL b2b_valid n=%0d got=%b want=%b", i - 4, vo, vq[i-4]);
        end
        checks++;
        if (yo !== ref_sig(xq[i-4])) begin
          failures++;
          $display("FAIL b2b_data n=%0d x=%h got=%h want=%h",
                   i - 4, xq[i-4], yo, ref_sig(xq[i-4]));
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic vo;
    logic [15:0] yo;
    logic [15:0] x0;
    for (int i = 0; i < 6; i++) tick(1'b1, 16'($urandom), vo, yo);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_valid got=%b want=0", valid_out);
    end
    checks++;
    if (data_out !== 16'h0000) begin
      failures++;
      $display("FAIL async_rst_data got=%h want=0000", data_out);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 16'($urandom), vo, yo);
      checks++;
      if (vo !== 1'b0 || yo !== 16'h0000) begin
        failures++;
        $display("FAIL rst_hold got=%b/%h want=0/0000", vo, yo);
      end
    end
    rst = 1'b0;
    valid_in = 1'b0;
    x0 = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      tick(i == 3, x0, vo, yo);
      checks++;
      if (vo !== (i == 7)) begin
        failures++;
        $display("FAIL rst_release_valid cyc=%0d got=%b want=%b",
                 i, vo, (i == 7));
      end
    end
    checks++;
    if (yo !== ref_sig(x0)) begin
      failures++;
      $display("FAIL rst_first_data x=%h got=%h want=%h", x0, yo, ref_sig(x0));
    end
  endtask

  task automatic test_sweep;
    logic vo;
    logic [15:0] yo, xj, prev;
    prev = 16'h0;
    for (int i = 0; i < 65540; i++) begin
      tick(i < 65536, 16'(i) ^ 16'h8000, vo, yo);
      if (i >= 4) begin
        xj = 16'(i - 4) ^ 16'h8000;
        checks++;
        if (vo !== 1'b1) begin
          failures++;
          $display("FAIL sweep_valid x=%h got=%b want=1", xj, vo);
        end
        checks++;
        if (yo !== ref_sig(xj)) begin
          failures++;
          $display("FAIL sweep_data x=%h got=%h want=%h", xj, yo, ref_sig(xj));
        end
        checks++;
        if (yo > 16'h8000) begin
          failures++;
          $display("FAIL sweep_max x=%h got=%h want<=8000", xj, yo);
        end
        if (i > 4) begin
          checks++;
          if (yo < prev) begin
            failures++;
            $display("FAIL sweep_mono x=%h got=%h want>=%h", xj, yo, prev);
          end
        end
        prev = yo;
      end
    end
  endtask

  initial begin
    for (int k = 0; k <= 32; k++)
      tab[k] = $rtoi($floor(32768.0 / (1.0 + $exp(-real'(k) / 4.0)) + 0.5));
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
